// File: rtl/bus_master.sv
// Single-outstanding bus master: accepts one user request, decodes it onto two slaves, returns one response.
// Optional WAIT-state abort counter enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        mode,
  output logic [15:0] addr,
  output logic [7:0]  wdata,
  output logic        valid,
  output logic [1:0]  sl,
  input  logic [7:0]  rdata,
  input  logic        ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        valid_q, valid_d;
  logic [1:0]  sl_q, sl_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Each slave owns a 2 KB window at the bottom of the map.
  logic [1:0] dec_sl;
  logic       dec_err;

  always_comb begin
    dec_sl  = 2'b00;
    dec_err = 1'b0;
    case (req_addr[15:11])
      5'd0:    dec_sl  = 2'b01;
      5'd1:    dec_sl  = 2'b10;
      default: dec_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    valid_d     = valid_q;
    sl_d        = sl_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef BUS_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (dec_err) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 8'h00;
            state_d     = RESP;
          end else begin
            mode_d  = req_mode;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            valid_d = 1'b1;
            sl_d    = dec_sl;
            state_d = WAIT;
`ifdef BUS_MASTER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      WAIT: begin
        if (ready) begin
          rsp_rdata_d = mode_q ? 8'h00 : rdata;
          rsp_err_d   = 1'b0;
          valid_d     = 1'b0;
          sl_d        = 2'b00;
          state_d     = RESP;
        end
`ifdef BUS_MASTER_TIMEOUT_EN
        // ready on the final cycle still wins over the abort.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          valid_d     = 1'b0;
          sl_d        = 2'b00;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 8'h00;
      valid_q     <= 1'b0;
      sl_q        <= 2'b00;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      valid_q     <= valid_d;
      sl_q        <= sl_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef BUS_MASTER_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mode      = mode_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign valid     = valid_q;
  assign sl        = sl_q;

endmodule
